// File: rtl/alu_wb_stage.sv
// ALU write-back stage.
// Buffers ALU results in a small FIFO with their {N,Z,C,V} flags. It also
// maintains the architectural flag register and a sticky overflow bit,
// both of which update on each accepted result.
module alu_wb_stage #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [31:0]                in_out,
  input  logic                       in_zero,
  input  logic                       in_overflow,
  input  logic                       in_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [3:0]                 out_flags,
  output logic [3:0]                 flags_q,
  output logic                       sticky_v,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // ADD, SUB and SLT produce meaningful carry/overflow; all other ops are logical.
  function automatic logic is_arith(input logic [2:0] op);
    logic r;
    case (op)
      OP_ADD:  r = 1'b1;
      OP_SUB:  r = 1'b1;
      OP_SLT:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Pack the ALU status outputs into {N,Z,C,V}.
  function automatic logic [3:0] pack_flags(input logic [31:0] res, input logic z,
                                            input logic c, input logic v);
    return {res[31], z, c, v};
  endfunction

  logic [31:0]   data_mem_r [DEPTH];
  logic [3:0]    flag_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [3:0]    flags_r;
  logic          sticky_r;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [3:0]    new_flags_s;
  logic          arith_s;

  // Both handshakes are derived only from registered occupancy, so nothing
  // passes through combinationally from input to output.
  assign full_s      = (count_r == CW'(DEPTH));
  assign empty_s     = (count_r == {CW{1'b0}});
  assign in_ready    = ~full_s;
  assign out_valid   = ~empty_s;
  assign push_s      = in_valid & ~full_s;
  assign pop_s       = out_ready & ~empty_s;
  assign new_flags_s = pack_flags(in_out, in_zero, in_cout, in_overflow);
  assign arith_s     = is_arith(in_op);
  assign count       = count_r;
  assign flags_q     = flags_r;
  assign sticky_v    = sticky_r;

  // Write accepted results into the storage array. Data is not reset, because
  // occupancy masks stale entries.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      data_mem_r[wr_ptr_r] <= in_out;
      flag_mem_r[wr_ptr_r] <= new_flags_s;
    end
  end

  // Update the pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Update the architectural flags on every push. Logical ops leave C and V untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= 4'b0000;
    end else if (push_s) begin
      if (arith_s) begin
        flags_r <= new_flags_s;
      end else begin
        flags_r <= {new_flags_s[3:2], flags_r[1:0]};
      end
    end else begin
      flags_r <= flags_r;
    end
  end

  // Sticky overflow. An overflowing arithmetic push beats a concurrent clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_r <= 1'b0;
    end else if (push_s && arith_s && in_overflow) begin
      sticky_r <= 1'b1;
    end else if (clr_sticky) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  // Present the head entry, or zeros while the FIFO is empty.
  always_comb begin
    out_data  = 32'h0000_0000;
    out_flags = 4'b0000;
    if (!empty_s) begin
      out_data  = data_mem_r[rd_ptr_r];
      out_flags = flag_mem_r[rd_ptr_r];
    end else begin
      out_data  = 32'h0000_0000;
      out_flags = 4'b0000;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage. Expected entries are pushed to a
// scoreboard queue when a push handshake is driven. They are popped and
// compared when the DUT presents them.
module tb_alu_wb_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_out;
  logic        in_zero;
  logic        in_overflow;
  logic        in_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [3:0]  flags_q;
  logic        sticky_v;
  logic        clr_sticky;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
  } ent_t;

  ent_t       sb_q[$];
  logic [3:0] exp_flags;
  logic       exp_sticky;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  alu_wb_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_out(in_out), .in_zero(in_zero),
    .in_overflow(in_overflow), .in_cout(in_cout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .flags_q(flags_q), .sticky_v(sticky_v), .clr_sticky(clr_sticky),
    .count(count)
  );

  always #5 clk = ~clk;

  // Advance one clock. Handshakes seen before the edge update the reference model.
  task automatic tick();
    bit   push_b;
    bit   pop_b;
    bit   arith_b;
    ent_t e;
    push_b  = in_valid && in_ready;
    pop_b   = out_valid && out_ready;
    arith_b = (in_op == 3'b010) || (in_op == 3'b110) || (in_op == 3'b111);
    if (rst) begin
      sb_q.delete();
      exp_flags  = 4'b0000;
      exp_sticky = 1'b0;
    end else begin
      if (pop_b && sb_q.size() != 0) void'(sb_q.pop_front());
      if (push_b) begin
        e.d = in_out;
        e.f = {in_out[31], in_zero, in_cout, in_overflow};
        sb_q.push_back(e);
        if (arith_b) exp_flags = e.f;
        else         exp_flags = {e.f[3:2], exp_flags[1:0]};
      end
      if (push_b && arith_b && in_overflow) exp_sticky = 1'b1;
      else if (clr_sticky)                  exp_sticky = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] res,
                       input logic z, input logic c, input logic v);
    in_valid = 1'b1; in_op = op; in_out = res;
    in_zero = z; in_cout = c; in_overflow = v;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_hs count=%0d out_valid=%b in_ready=%b exp 0/0/1", count, out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (flags_q !== 4'b0000 || sticky_v !== 1'b0)
      $display("FAIL reset_flags flags_q=%b sticky=%b exp 0000/0", flags_q, sticky_v);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 32'h0 || out_flags !== 4'b0000)
      $display("FAIL reset_out data=%h flags=%b exp 0/0000", out_data, out_flags);
    else pass_cnt++;
  endtask

  task automatic test_first_push();
    out_ready = 1'b0;
    drive(3'b010, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h0 || out_flags !== 4'b0110)
      $display("FAIL first_push valid=%b data=%h flags=%b exp 1/0/0110", out_valid, out_data, out_flags);
    else pass_cnt++;
    total_cnt++;
    if (flags_q !== 4'b0110)
      $display("FAIL first_flags_q got %b exp 0110", flags_q);
    else pass_cnt++;
    out_ready = 1'b1;
    total_cnt++;
    if (sb_q.size() == 0 || out_data !== sb_q[0].d || out_flags !== sb_q[0].f)
      $display("FAIL first_head got %h/%b exp %h/%b", out_data, out_flags, sb_q[0].d, sb_q[0].f);
    else pass_cnt++;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL first_drain count=%0d valid=%b exp 0/0", count, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(3'b000, 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    total_cnt++;
    if (count !== 3'd4 || in_ready !== 1'b0)
      $display("FAIL fill_full count=%0d in_ready=%b exp 4/0", count, in_ready);
    else pass_cnt++;
    drive(3'b000, 32'd5, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd4 || out_data !== 32'd1)
      $display("FAIL fill_hold count=%0d head=%h exp 4/1", count, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total_cnt++;
      if (sb_q.size() == 0 || out_data !== sb_q[0].d || out_data !== 32'(i) || out_flags !== sb_q[0].f)
        $display("FAIL fill_pop%0d got %h/%b exp %h/%b", i, out_data, out_flags, sb_q[0].d, sb_q[0].f);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b0;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL fill_empty count=%0d valid=%b data=%h exp 0/0/0", count, out_valid, out_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(3'b001, 32'd100, 1'b0, 1'b0, 1'b0); tick();
    drive(3'b001, 32'd101, 1'b0, 1'b0, 1'b0); tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(3'b001, 32'(102 + k), 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (count !== 3'd2 || sb_q.size() == 0 || out_data !== sb_q[0].d || out_data !== 32'(100 + k))
        $display("FAIL b2b_%0d count=%0d data=%h exp 2/%h", k, count, out_data, 32'(100 + k));
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      total_cnt++;
      if (sb_q.size() == 0 || out_data !== 32'(100 + k))
        $display("FAIL b2b_drain%0d data=%h exp %h", k, out_data, 32'(100 + k));
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b0;
    total_cnt++;
    if (count !== 3'd0)
      $display("FAIL b2b_empty count=%0d exp 0", count);
    else pass_cnt++;
  endtask

  task automatic test_flags();
    out_ready = 1'b0;
    drive(3'b110, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    tick();
    total_cnt++;
    if (flags_q !== 4'b1001 || sticky_v !== 1'b1)
      $display("FAIL sub_flags flags_q=%b sticky=%b exp 1001/1", flags_q, sticky_v);
    else pass_cnt++;
    drive(3'b000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    tick();
    total_cnt++;
    if (flags_q !== 4'b0001 || sticky_v !== 1'b1)
      $display("FAIL and_flags flags_q=%b sticky=%b exp 0001/1", flags_q, sticky_v);
    else pass_cnt++;
    in_valid = 1'b0; clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    total_cnt++;
    if (sticky_v !== 1'b0 || flags_q !== 4'b0001)
      $display("FAIL clr_sticky sticky=%b flags_q=%b exp 0/0001", sticky_v, flags_q);
    else pass_cnt++;
    drive(3'b100, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1);
    tick();
    total_cnt++;
    if (sticky_v !== 1'b0 || flags_q !== 4'b1001)
      $display("FAIL logic_ovf sticky=%b flags_q=%b exp 0/1001", sticky_v, flags_q);
    else pass_cnt++;
    drive(3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (sticky_v !== 1'b1 || flags_q !== 4'b1011 || flags_q !== exp_flags)
      $display("FAIL set_wins sticky=%b flags_q=%b exp 1/1011", sticky_v, flags_q);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (sb_q.size() == 0 || out_data !== sb_q[0].d || out_flags !== sb_q[0].f)
        $display("FAIL flags_pop%0d got %h/%b exp %h/%b", i, out_data, out_flags, sb_q[0].d, sb_q[0].f);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b0;
    total_cnt++;
    if (flags_q !== exp_flags || sticky_v !== exp_sticky || count !== 3'd0)
      $display("FAIL flags_model flags_q=%b sticky=%b count=%0d exp %b/%b/0", flags_q, sticky_v, count, exp_flags, exp_sticky);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'b110, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b1, 1'b1);
      tick();
    end
    rst = 1'b1; clr_sticky = 1'b1; out_ready = 1'b1;
    drive(3'b010, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0; clr_sticky = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_hs count=%0d valid=%b in_ready=%b exp 0/0/1", count, out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (flags_q !== 4'b0000 || sticky_v !== 1'b0)
      $display("FAIL rst_mid_flags flags_q=%b sticky=%b exp 0000/0", flags_q, sticky_v);
    else pass_cnt++;
    drive(3'b000, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd1 || out_data !== 32'hA5A5_A5A5 || sb_q.size() != 1 || out_data !== sb_q[0].d)
      $display("FAIL rst_mid_head count=%0d data=%h exp 1/a5a5a5a5", count, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL rst_mid_drain count=%0d valid=%b data=%h exp 0/0/0", count, out_valid, out_data);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_out = 32'h0;
    in_zero = 1'b0; in_overflow = 1'b0; in_cout = 1'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    exp_flags = 4'b0000; exp_sticky = 1'b0;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    test_reset();
    test_first_push();
    test_fill();
    test_back_to_back();
    test_flags();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter: DEPTH, default 4, result FIFO depth in entries (power of two, 2..16).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  ALU result presented this cycle.
REQ-005 in_ready  output  1  stage can accept an ALU result.
REQ-006 in_op  input  3  ALU op code that produced the result.
REQ-007 in_out  input  32  ALU result word.
REQ-008 in_zero  input  1  ALU zero flag.
REQ-009 in_overflow  input  1  ALU signed-overflow flag.
REQ-010 in_cout  input  1  ALU carry-out of bit 31.
REQ-011 out_valid  output  1  FIFO head entry is valid.
REQ-012 out_ready  input  1  consumer takes the head entry.
REQ-013 out_data  output  32  head entry result word.
REQ-014 out_flags  output  4  head entry flags {N,Z,C,V}.
REQ-015 flags_q  output  4  architectural flag register {N,Z,C,V}.
REQ-016 sticky_v  output  1  sticky overflow indicator.
REQ-017 clr_sticky  input  1  clears sticky_v.
REQ-018 count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.

Function
REQ-019 Push occurs on a cycle with in_valid=1 and in_ready=1; pop occurs on a cycle with out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL equal (count != DEPTH), combinationally from registered state only; no full-bypass.
REQ-021 out_valid SHALL equal (count != 0); out_data/out_flags SHALL show the head entry and remain stable while out_valid=1 and out_ready=0.
REQ-022 Entry flags: N=in_out[31], Z=in_zero, C=in_cout, V=in_overflow, captured at push.
REQ-023 Latency: a push into an empty FIFO SHALL make out_valid=1 on the following cycle; no same-cycle pass-through.
REQ-024 Simultaneous push and pop with 0<count<DEPTH: count unchanged, ordering preserved (FIFO order).
REQ-025 Pop when count=0 and push when count=DEPTH SHALL not be possible (handshake gated); in_valid while full is held off, no data lost or overwritten.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-027 On push with in_op in {3'b010 ADD, 3'b110 SUB, 3'b111 SLT}: flags_q <= {N,Z,C,V} of the pushed entry.
REQ-028 On push with any other in_op (logic ops): flags_q[2:0]... only N and Z updated; C and V retained.
REQ-029 sticky_v SHALL set on a push of an arithmetic op (REQ-027 set) with in_overflow=1; clear when clr_sticky=1; set wins when both occur in one cycle.
REQ-030 flags_q and sticky_v SHALL update on push cycle edge, independent of pop activity and out_ready.
REQ-031 out_data/out_flags SHALL read 0 when count=0.

Reset
REQ-032 rst=1 at a clock edge SHALL set count=0, pointers=0, flags_q=4'b0000, sticky_v=0; out_valid=0, in_ready=1 in the following cycle.
REQ-033 rst SHALL take priority over push, pop and clr_sticky in the same cycle; FIFO contents after reset mid-operation SHALL be discarded and not reappear.

Verification
REQ-034 Reset, then push ADD result 0x00000000 zero=1 cout=1 ovf=0 -> next cycle out_valid=1, out_data=0, out_flags=4'b0110, flags_q=4'b0110.
REQ-035 out_ready=0, push 4 entries 1,2,3,4 -> count=4, in_ready=0; 5th in_valid ignored; then out_ready=1 four cycles -> pops 1,2,3,4 in order, count=0.
REQ-036 count=2, push and pop same cycle for 10 cycles with incrementing data -> count stays 2, output sequence strictly in push order across pointer wrap.
REQ-037 Push SUB 0x7FFFFFFF-0xFFFFFFFF result 0x80000000 ovf=1 cout=0 -> flags_q=4'b1001, sticky_v=1; then push AND 0x00000001 -> flags_q=4'b0001, sticky_v stays 1; clr_sticky with concurrent overflowing ADD push -> sticky_v=1.
REQ-038 Fill 3 entries, assert rst one cycle -> count=0, out_valid=0, flags_q=0, sticky_v=0; next push 0xA5A5A5A5 appears as sole head entry.
